// File: rtl/ws2812_matrix_scheduler_if.sv
// Host write port, clear/refresh control, framebuffer memory port and
// serializer pixel stream of the WS2812 matrix scheduler.
interface ws2812_matrix_scheduler_if;
    logic        host_valid;
    logic        host_ready;
    logic [7:0]  host_row;
    logic [7:0]  host_col;
    logic [23:0] host_rgb;
    logic        host_oob;
    logic        clear_req;
    logic        clear_busy;
    logic        frame_start;
    logic        frame_busy;
    logic [7:0]  mem_row;
    logic [7:0]  mem_col;
    logic        mem_wr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        pix_last;

    modport slave (
        input  host_valid, host_row, host_col, host_rgb, clear_req, frame_start,
               mem_rdata, pix_ready,
        output host_ready, host_oob, clear_busy, frame_busy, mem_row, mem_col,
               mem_wr, mem_wdata, pix_valid, pix_data, pix_last
    );

    modport master (
        output host_valid, host_row, host_col, host_rgb, clear_req, frame_start,
               mem_rdata, pix_ready,
        input  host_ready, host_oob, clear_busy, frame_busy, mem_row, mem_col,
               mem_wr, mem_wdata, pix_valid, pix_data, pix_last
    );
endinterface

// File: rtl/ws2812_matrix_scheduler.sv
// Arbitrates the WS2812 framebuffer between host pixel writes, full-frame
// clears and refresh scans that stream pixels in LED-chain order.
module ws2812_matrix_scheduler #(
    parameter int          WIDTH      = 32,
    parameter int          HEIGHT     = 16,
    parameter int          SERPENTINE = 1,
    parameter logic [23:0] CLEAR_RGB  = 24'hFF0000
) (
    input  logic clk,
    input  logic rst_n,
    ws2812_matrix_scheduler_if.slave bus
);

    localparam logic [7:0] COL_MAX = 8'(WIDTH - 1);
    localparam logic [7:0] ROW_MAX = 8'(HEIGHT - 1);
    localparam logic [8:0] WIDTH9  = 9'(WIDTH);
    localparam logic [8:0] HEIGHT9 = 9'(HEIGHT);

    typedef enum logic [2:0] {
        IDLE,
        HOST_WR,
        HOST_HOLD,
        CLEAR_WR,
        CLEAR_HOLD,
        SCAN_RD,
        SCAN_OUT
    } state_t;

    state_t state;
    logic   clear_pend;
    logic   frame_pend;
    logic   host_acc;
    logic   host_in_range;
    logic   clear_want;
    logic   enter_clear;
    logic   enter_scan;

    function automatic logic row_reversed(input logic [7:0] r);
        return (SERPENTINE != 0) && r[0];
    endfunction

    function automatic logic [7:0] row_first_col(input logic [7:0] r);
        return row_reversed(r) ? COL_MAX : 8'd0;
    endfunction

    function automatic logic [7:0] row_last_col(input logic [7:0] r);
        return row_reversed(r) ? 8'd0 : COL_MAX;
    endfunction

    assign bus.host_ready = (state == IDLE) && !clear_pend && !frame_pend;
    assign host_acc       = bus.host_valid && bus.host_ready;
    assign host_in_range  = ({1'b0, bus.host_row} < HEIGHT9) &&
                            ({1'b0, bus.host_col} < WIDTH9);
    assign clear_want     = bus.clear_req || clear_pend;
    assign enter_clear    = (state == IDLE) && !host_acc && clear_want;
    assign enter_scan     = (state == IDLE) && !host_acc && !clear_want &&
                            (bus.frame_start || frame_pend);

    assign bus.clear_busy = clear_pend || (state == CLEAR_WR) || (state == CLEAR_HOLD);
    assign bus.frame_busy = frame_pend || (state == SCAN_RD) || (state == SCAN_OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            clear_pend    <= 1'b0;
            frame_pend    <= 1'b0;
            bus.host_oob  <= 1'b0;
            bus.mem_row   <= 8'd0;
            bus.mem_col   <= 8'd0;
            bus.mem_wr    <= 1'b0;
            bus.mem_wdata <= 24'd0;
            bus.pix_valid <= 1'b0;
            bus.pix_data  <= 24'd0;
            bus.pix_last  <= 1'b0;
        end else begin
            bus.host_oob <= 1'b0;

            // Requests seen while another job owns the memory collapse into one pending flag.
            if (enter_clear)        clear_pend <= 1'b0;
            else if (bus.clear_req) clear_pend <= 1'b1;
            if (enter_scan)           frame_pend <= 1'b0;
            else if (bus.frame_start) frame_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (host_acc) begin
                        if (host_in_range) begin
                            bus.mem_row   <= bus.host_row;
                            bus.mem_col   <= bus.host_col;
                            bus.mem_wdata <= bus.host_rgb;
                            bus.mem_wr    <= 1'b1;
                            state         <= HOST_WR;
                        end else begin
                            bus.host_oob <= 1'b1;
                        end
                    end else if (enter_clear) begin
                        bus.mem_row   <= 8'd0;
                        bus.mem_col   <= 8'd0;
                        bus.mem_wdata <= CLEAR_RGB;
                        bus.mem_wr    <= 1'b1;
                        state         <= CLEAR_WR;
                    end else if (enter_scan) begin
                        bus.mem_row <= 8'd0;
                        bus.mem_col <= row_first_col(8'd0);
                        state       <= SCAN_RD;
                    end
                end
                HOST_WR: begin
                    bus.mem_wr <= 1'b0;
                    state      <= HOST_HOLD;
                end
                HOST_HOLD: begin
                    state <= IDLE;
                end
                CLEAR_WR: begin
                    bus.mem_wr <= 1'b0;
                    state      <= CLEAR_HOLD;
                end
                CLEAR_HOLD: begin
                    if ((bus.mem_row == ROW_MAX) && (bus.mem_col == COL_MAX)) begin
                        state <= IDLE;
                    end else begin
                        if (bus.mem_col == COL_MAX) begin
                            bus.mem_row <= bus.mem_row + 8'd1;
                            bus.mem_col <= 8'd0;
                        end else begin
                            bus.mem_col <= bus.mem_col + 8'd1;
                        end
                        bus.mem_wr <= 1'b1;
                        state      <= CLEAR_WR;
                    end
                end
                SCAN_RD: begin
                    bus.pix_data  <= bus.mem_rdata;
                    bus.pix_valid <= 1'b1;
                    bus.pix_last  <= (bus.mem_row == ROW_MAX) &&
                                     (bus.mem_col == row_last_col(bus.mem_row));
                    state         <= SCAN_OUT;
                end
                SCAN_OUT: begin
                    if (bus.pix_ready) begin
                        bus.pix_valid <= 1'b0;
                        bus.pix_last  <= 1'b0;
                        if (bus.pix_last) begin
                            state <= IDLE;
                        end else begin
                            // Row ends alternate sides in serpentine wiring.
                            if (bus.mem_col == row_last_col(bus.mem_row)) begin
                                bus.mem_row <= bus.mem_row + 8'd1;
                                bus.mem_col <= row_first_col(bus.mem_row + 8'd1);
                            end else if (row_reversed(bus.mem_row)) begin
                                bus.mem_col <= bus.mem_col - 8'd1;
                            end else begin
                                bus.mem_col <= bus.mem_col + 8'd1;
                            end
                            state <= SCAN_RD;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.mem_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_matrix_scheduler.sv
// Scoreboard bench for the WS2812 matrix scheduler on a 4x2 serpentine matrix
// backed by a small framebuffer model.
module tb_ws2812_matrix_scheduler;

    localparam int W = 4;
    localparam int H = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [39:0] exp_wr[$];
    logic [24:0] exp_pix[$];
    logic [23:0] fb [H][W];

    ws2812_matrix_scheduler_if bus();

    ws2812_matrix_scheduler #(
        .WIDTH(W), .HEIGHT(H), .SERPENTINE(1), .CLEAR_RGB(24'hFF0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = (bus.mem_row < 8'(H) && bus.mem_col < 8'(W)) ?
                           fb[bus.mem_row[0]][bus.mem_col[1:0]] : 24'd0;

    always @(posedge clk) begin
        if (bus.mem_wr && bus.mem_row < 8'(H) && bus.mem_col < 8'(W))
            fb[bus.mem_row[0]][bus.mem_col[1:0]] <= bus.mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [39:0] ew;
        logic [24:0] ep;
        if (bus.mem_wr) begin
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mem_wr_unexpected got=%h expected=none at %0t",
                         {bus.mem_row, bus.mem_col, bus.mem_wdata}, $time);
            end else begin
                ew = exp_wr.pop_front();
                chk("mem_wr", 64'({bus.mem_row, bus.mem_col, bus.mem_wdata}), 64'(ew));
            end
        end
        if (bus.pix_valid && bus.pix_ready) begin
            if (exp_pix.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pix_unexpected got=%h expected=none at %0t",
                         {bus.pix_last, bus.pix_data}, $time);
            end else begin
                ep = exp_pix.pop_front();
                chk("pix", 64'({bus.pix_last, bus.pix_data}), 64'(ep));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // Waits for host_ready, issues one write, returns oob seen after accept and
    // the number of cycles host_ready stayed low afterwards.
    task automatic host_write(input logic [7:0] r, input logic [7:0] c, input logic [23:0] d,
                              output logic oob, output int lowcnt);
        int n;
        n = 0;
        while (!bus.host_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) chk("host_ready_timeout", 64'(0), 64'(1));
        bus.host_valid = 1'b1;
        bus.host_row   = r;
        bus.host_col   = c;
        bus.host_rgb   = d;
        if (r < 8'(H) && c < 8'(W)) exp_wr.push_back({r, c, d});
        @(posedge clk); #1;
        bus.host_valid = 1'b0;
        oob = bus.host_oob;
        lowcnt = 0;
        while (!bus.host_ready && lowcnt < 20) begin
            lowcnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_frame();
        @(posedge clk); #1;
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
    endtask

    initial begin
        logic        oob;
        int          lc;
        int          cnt;
        int          ord_r[8];
        int          ord_c[8];
        logic [23:0] d;

        ord_r = '{0, 0, 0, 0, 1, 1, 1, 1};
        ord_c = '{0, 1, 2, 3, 3, 2, 1, 0};
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.host_valid  = 1'b0;
        bus.host_row    = 8'd0;
        bus.host_col    = 8'd0;
        bus.host_rgb    = 24'd0;
        bus.clear_req   = 1'b0;
        bus.frame_start = 1'b0;
        bus.pix_ready   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_wr", 64'(bus.mem_wr), 64'(0));
        chk("rst_pix_valid", 64'(bus.pix_valid), 64'(0));
        chk("rst_outputs", 64'({bus.mem_row, bus.mem_col, bus.mem_wdata, bus.pix_data,
                                bus.pix_last, bus.host_oob}), 64'(0));
        chk("rst_host_ready", 64'(bus.host_ready), 64'(1));
        chk("rst_busy", 64'({bus.clear_busy, bus.frame_busy}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single in-range write
        host_write(8'd1, 8'd2, 24'h123456, oob, lc);
        chk("wr_oob", 64'(oob), 64'(0));
        chk("wr_ready_low", 64'(lc), 64'(2));

        // Out-of-range writes
        host_write(8'd2, 8'd0, 24'h777777, oob, lc);
        chk("oob_row_pulse", 64'(oob), 64'(1));
        chk("oob_row_ready_low", 64'(lc), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("oob_pulse_end", 64'(bus.host_oob), 64'(0));
            chk("oob_no_wr", 64'(bus.mem_wr), 64'(0));
        end
        host_write(8'd0, 8'd4, 24'h888888, oob, lc);
        chk("oob_col_pulse", 64'(oob), 64'(1));

        // Fill with distinct values, then scan in serpentine order
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                host_write(8'(r), 8'(c), 24'hA00000 | 24'(r << 8) | 24'(c), oob, lc);
        for (int i = 0; i < 8; i++) begin
            d = 24'hA00000 | 24'(ord_r[i] << 8) | 24'(ord_c[i]);
            exp_pix.push_back({(i == 7), d});
        end
        bus.pix_ready = 1'b1;
        pulse_frame();
        chk("scan_first_pv", 64'(bus.pix_valid), 64'(0));
        cnt = 0;
        while (bus.frame_busy && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("scan_cycles", 64'(cnt), 64'(16));

        // Clear and frame requested together
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_wr.push_back({8'(r), 8'(c), 24'hFF0000});
        for (int i = 0; i < 8; i++) exp_pix.push_back({(i == 7), 24'hFF0000});
        @(posedge clk); #1;
        bus.clear_req   = 1'b1;
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.clear_req   = 1'b0;
        bus.frame_start = 1'b0;
        chk("cf_frame_pend", 64'(bus.frame_busy), 64'(1));
        cnt = 0;
        while (bus.clear_busy && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("clear_cycles", 64'(cnt), 64'(16));
        cnt = 0;
        while (bus.frame_busy && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("cf_scan_done", 64'(bus.frame_busy), 64'(0));

        // Backpressure during a scan with a host write stalled behind it
        host_write(8'd0, 8'd0, 24'hABCDEF, oob, lc);
        host_write(8'd0, 8'd1, 24'h00FF00, oob, lc);
        exp_pix.push_back({1'b0, 24'hABCDEF});
        exp_pix.push_back({1'b0, 24'h00FF00});
        for (int i = 0; i < 6; i++) exp_pix.push_back({(i == 5), 24'hFF0000});
        bus.pix_ready = 1'b0;
        pulse_frame();
        bus.host_valid = 1'b1;
        bus.host_row   = 8'd1;
        bus.host_col   = 8'd1;
        bus.host_rgb   = 24'h0A0B0C;
        exp_wr.push_back({8'd1, 8'd1, 24'h0A0B0C});
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(bus.pix_valid), 64'(1));
            chk("stall_data", 64'(bus.pix_data), 64'(24'hABCDEF));
            chk("stall_host", 64'(bus.host_ready), 64'(0));
            @(posedge clk); #1;
        end
        bus.pix_ready = 1'b1;
        cnt = 0;
        while (bus.frame_busy && cnt < 100) begin
            chk("scan_host_blocked", 64'(bus.host_ready), 64'(0));
            cnt++;
            @(posedge clk); #1;
        end
        chk("post_scan_ready", 64'(bus.host_ready), 64'(1));
        @(posedge clk); #1;
        bus.host_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a clear: only the first two pixel writes occur
        exp_wr.push_back({8'd0, 8'd0, 24'hFF0000});
        exp_wr.push_back({8'd0, 8'd1, 24'hFF0000});
        @(posedge clk); #1;
        bus.clear_req = 1'b1;
        @(posedge clk); #1;
        bus.clear_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_wr", 64'(bus.mem_wr), 64'(0));
        chk("midrst_clear_busy", 64'(bus.clear_busy), 64'(0));
        chk("midrst_host_ready", 64'(bus.host_ready), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("after_rst_idle", 64'({bus.host_ready, bus.clear_busy}), 64'(2'b10));
        end

        chk("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
        chk("pix_queue_empty", 64'(exp_pix.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
